// File: rtl/shift_unit_pipe.sv
// Pipelined shift/rotate unit: log-shifter levels applied largest-first, split across
// registered stages joined by valid/ready handshakes with flush and a pass-through tag.
module shift_unit_pipe #(
    parameter int XLEN           = 32,
    parameter int LVLS_PER_STAGE = 2,
    parameter int TAG_W          = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [XLEN-1:0]  i_a,
    input  logic [XLEN-1:0]  i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);

    localparam int unsigned L      = $clog2(XLEN);
    localparam int unsigned STAGES = (L + LVLS_PER_STAGE - 1) / LVLS_PER_STAGE;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [XLEN-1:0]   data_q  [STAGES];
    logic [XLEN-1:0]   data_d  [STAGES];
    logic [2:0]        op_q    [STAGES];
    logic [2:0]        op_d    [STAGES];
    logic [L-1:0]      sh_q    [STAGES];
    logic [L-1:0]      sh_d    [STAGES];
    logic              fill_q  [STAGES];
    logic              fill_d  [STAGES];
    logic [TAG_W-1:0]  tag_q   [STAGES];
    logic [TAG_W-1:0]  tag_d   [STAGES];
    logic              busy_q, busy_d;

    logic [XLEN-1:0]   in_data [STAGES];
    logic [2:0]        in_op   [STAGES];
    logic [L-1:0]      in_sh   [STAGES];
    logic              in_fill [STAGES];
    logic [TAG_W-1:0]  in_tag  [STAGES];

    logic [STAGES:0]   free;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;
    logic              accept;

    // Upper shift-amount bits and the last stage's control fields are never consumed.
    logic unused_bits;
    assign unused_bits = ^{i_b[XLEN-1:L], op_q[STAGES-1], sh_q[STAGES-1], fill_q[STAGES-1]};

    function automatic logic [XLEN-1:0] shift_level(
        input logic [XLEN-1:0] d,
        input logic [2:0]      op,
        input logic            fill,
        input int unsigned     n
    );
        logic [XLEN-1:0] ones;
        logic [XLEN-1:0] r;
        ones = '1;
        case (op)
            OP_SLL:  r = d << n;
            OP_SRL:  r = d >> n;
            OP_SRA:  r = (d >> n) | (fill ? ~(ones >> n) : '0);
            OP_ROL:  r = (d << n) | (d >> (XLEN - n));
            OP_ROR:  r = (d >> n) | (d << (XLEN - n));
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] stage_apply(
        input logic [XLEN-1:0] d,
        input logic [2:0]      op,
        input logic            fill,
        input logic [L-1:0]    sh,
        input int unsigned     s
    );
        logic [XLEN-1:0] r;
        r = d;
        for (int unsigned k = 0; k < L; k++) begin
            if (((k / LVLS_PER_STAGE) == s) && sh[L-1-k]) begin
                r = shift_level(r, op, fill, 32'd1 << (L - 1 - k));
            end
        end
        return r;
    endfunction

    // Ready ripples back from the consumer: a stage is free if empty or advancing.
    always_comb begin
        free         = '0;
        adv          = '0;
        free[STAGES] = i_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            adv[STAGES-1-i]  = valid_q[STAGES-1-i] && free[STAGES-i];
            free[STAGES-1-i] = !valid_q[STAGES-1-i] || adv[STAGES-1-i];
        end
    end

    assign accept = i_valid && free[0] && !i_flush;

    always_comb begin
        ld         = '0;
        ld[0]      = accept;
        in_data[0] = i_a;
        in_op[0]   = i_op;
        in_sh[0]   = i_b[L-1:0];
        in_fill[0] = i_a[XLEN-1];
        in_tag[0]  = i_tag;
        for (int unsigned s = 1; s < STAGES; s++) begin
            ld[s]      = adv[s-1];
            in_data[s] = data_q[s-1];
            in_op[s]   = op_q[s-1];
            in_sh[s]   = sh_q[s-1];
            in_fill[s] = fill_q[s-1];
            in_tag[s]  = tag_q[s-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int unsigned s = 0; s < STAGES; s++) begin
            data_d[s] = data_q[s];
            op_d[s]   = op_q[s];
            sh_d[s]   = sh_q[s];
            fill_d[s] = fill_q[s];
            tag_d[s]  = tag_q[s];
            if (ld[s]) begin
                data_d[s] = stage_apply(in_data[s], in_op[s], in_fill[s], in_sh[s], s);
                op_d[s]   = in_op[s];
                sh_d[s]   = in_sh[s];
                fill_d[s] = in_fill[s];
                tag_d[s]  = in_tag[s];
            end
            if (i_flush) begin
                valid_d[s] = 1'b0;
            end else if (ld[s]) begin
                valid_d[s] = 1'b1;
            end else if (adv[s]) begin
                valid_d[s] = 1'b0;
            end
        end
        busy_d = |valid_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            busy_q  <= 1'b0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                op_q[s]   <= '0;
                sh_q[s]   <= '0;
                fill_q[s] <= 1'b0;
                tag_q[s]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            for (int unsigned s = 0; s < STAGES; s++) begin
                data_q[s] <= data_d[s];
                op_q[s]   <= op_d[s];
                sh_q[s]   <= sh_d[s];
                fill_q[s] <= fill_d[s];
                tag_q[s]  <= tag_d[s];
            end
        end
    end

    assign o_ready  = free[0];
    assign o_valid  = valid_q[STAGES-1];
    assign o_result = data_q[STAGES-1];
    assign o_tag    = tag_q[STAGES-1];
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe: directed 32-bit vectors plus a 64-bit sweep
// over three stage splits, with queued expectations popped by output monitors.
module tb_shift_unit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        m_flush, m_valid, m_ordy, m_ovalid, m_irdy, m_busy;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_res;
    logic [4:0]  m_tag, m_otag;

    logic        s_valid;
    logic [2:0]  s_op;
    logic [63:0] s_a, s_b;
    logic [4:0]  s_tag;
    logic [2:0]  s_ordy, s_ovalid, s_busy;
    logic [63:0] s_res  [3];
    logic [4:0]  s_otag [3];

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t mq[$];
    exp_t sq0[$];
    exp_t sq1[$];
    exp_t sq2[$];
    exp_t me, se0, se1, se2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int w;

    always @(posedge clk) cyc <= cyc + 1;

    shift_unit_pipe #(.XLEN(32), .LVLS_PER_STAGE(2), .TAG_W(5)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(m_flush), .i_valid(m_valid), .o_ready(m_ordy),
        .i_op(m_op), .i_a(m_a), .i_b(m_b), .i_tag(m_tag), .o_valid(m_ovalid), .i_ready(m_irdy),
        .o_result(m_res), .o_tag(m_otag), .o_busy(m_busy)
    );

    shift_unit_pipe #(.XLEN(64), .LVLS_PER_STAGE(1), .TAG_W(5)) u_s1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_valid(s_valid), .o_ready(s_ordy[0]),
        .i_op(s_op), .i_a(s_a), .i_b(s_b), .i_tag(s_tag), .o_valid(s_ovalid[0]), .i_ready(1'b1),
        .o_result(s_res[0]), .o_tag(s_otag[0]), .o_busy(s_busy[0])
    );

    shift_unit_pipe #(.XLEN(64), .LVLS_PER_STAGE(3), .TAG_W(5)) u_s3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_valid(s_valid), .o_ready(s_ordy[1]),
        .i_op(s_op), .i_a(s_a), .i_b(s_b), .i_tag(s_tag), .o_valid(s_ovalid[1]), .i_ready(1'b1),
        .o_result(s_res[1]), .o_tag(s_otag[1]), .o_busy(s_busy[1])
    );

    shift_unit_pipe #(.XLEN(64), .LVLS_PER_STAGE(6), .TAG_W(5)) u_s6 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_valid(s_valid), .o_ready(s_ordy[2]),
        .i_op(s_op), .i_a(s_a), .i_b(s_b), .i_tag(s_tag), .o_valid(s_ovalid[2]), .i_ready(1'b1),
        .o_result(s_res[2]), .o_tag(s_otag[2]), .o_busy(s_busy[2])
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic timeout(input string what);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", what);
    endtask

    task automatic unexpected(input string name, input logic [63:0] got);
        checks++;
        failures++;
        $display("FAIL %s: got output %h, expected no output", name, got);
    endtask

    // Rotates use single-bit steps so the model shares no structure with a log shifter.
    function automatic logic [63:0] ref64(input logic [2:0] op, input logic [63:0] a, input int unsigned sh);
        logic [63:0] r;
        r = a;
        case (op)
            3'd0: r = a << sh;
            3'd1: r = a >> sh;
            3'd2: r = 64'($signed(a) >>> sh);
            3'd3: for (int unsigned i = 0; i < sh; i++) r = {r[62:0], r[63]};
            3'd4: for (int unsigned i = 0; i < sh; i++) r = {r[0], r[63:1]};
            default: r = a;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && m_ovalid && m_irdy) begin
            if (mq.size() == 0) begin
                unexpected("main_output", 64'(m_res));
            end else begin
                me = mq.pop_front();
                chk("main_result", 64'(m_res), me.data);
                chk("main_tag", 64'(m_otag), 64'(me.tag));
                if (me.lat) chk("main_latency", 64'(cyc - me.cyc), 64'd3);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_ovalid[0]) begin
            if (sq0.size() == 0) unexpected("sweep_lps1_output", s_res[0]);
            else begin
                se0 = sq0.pop_front();
                chk("sweep_lps1_result", s_res[0], se0.data);
                chk("sweep_lps1_tag", 64'(s_otag[0]), 64'(se0.tag));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_ovalid[1]) begin
            if (sq1.size() == 0) unexpected("sweep_lps3_output", s_res[1]);
            else begin
                se1 = sq1.pop_front();
                chk("sweep_lps3_result", s_res[1], se1.data);
                chk("sweep_lps3_tag", 64'(s_otag[1]), 64'(se1.tag));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_ovalid[2]) begin
            if (sq2.size() == 0) unexpected("sweep_lps6_output", s_res[2]);
            else begin
                se2 = sq2.pop_front();
                chk("sweep_lps6_result", s_res[2], se2.data);
                chk("sweep_lps6_tag", 64'(s_otag[2]), 64'(se2.tag));
            end
        end
    end

    task automatic send_main(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tag, input logic [31:0] exp, input bit lat,
                             output int waits);
        exp_t e;
        bit done;
        m_valid = 1'b1; m_op = op; m_a = a; m_b = b; m_tag = tag;
        waits = 0;
        done  = 1'b0;
        while (!done && waits < 64) begin
            @(negedge clk);
            if (m_ordy) begin
                e.data = {32'h0, exp}; e.tag = tag; e.cyc = cyc; e.lat = lat;
                mq.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        m_valid = 1'b0;
        if (!done) timeout("main_send");
    endtask

    task automatic send_sweep(input logic [2:0] op, input logic [63:0] a, input int unsigned sh,
                              input logic [4:0] tag);
        exp_t e;
        logic [63:0] rb;
        bit done;
        int n;
        rb = {$urandom, $urandom};
        s_valid = 1'b1; s_op = op; s_a = a; s_b = {rb[63:6], 6'(sh)}; s_tag = tag;
        done = 1'b0;
        n    = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            if (&s_ordy) begin
                e.data = ref64(op, a, sh); e.tag = tag; e.cyc = cyc; e.lat = 1'b0;
                sq0.push_back(e); sq1.push_back(e); sq2.push_back(e);
                done = 1'b1;
            end else begin
                n++;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!done) timeout("sweep_send");
    endtask

    task automatic drain(input string what);
        int n;
        n = 0;
        while ((mq.size() != 0 || sq0.size() != 0 || sq1.size() != 0 || sq2.size() != 0 ||
                m_busy || (|s_busy)) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) timeout(what);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; m_flush = 1'b0; m_valid = 1'b0; m_irdy = 1'b1;
        m_op = '0; m_a = '0; m_b = '0; m_tag = '0;
        s_valid = 1'b0; s_op = '0; s_a = '0; s_b = '0; s_tag = '0;
        #12;
        chk("reset_valid", 64'(m_ovalid), 64'd0);
        chk("reset_busy", 64'(m_busy), 64'd0);
        chk("reset_result", 64'(m_res), 64'd0);
        chk("reset_tag", 64'(m_otag), 64'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("reset_ready", 64'(m_ordy), 64'd1);
        @(posedge clk); #1;

        send_main(3'b010, 32'h8000_0000, 32'd31, 5'd1, 32'hFFFF_FFFF, 1'b1, w);
        send_main(3'b001, 32'h8000_0000, 32'd31, 5'd2, 32'h0000_0001, 1'b1, w);
        send_main(3'b000, 32'h0000_0001, 32'h25,  5'd3, 32'h0000_0020, 1'b1, w);
        send_main(3'b011, 32'h8000_0001, 32'd4,  5'd4, 32'h0000_0018, 1'b1, w);
        send_main(3'b100, 32'h0000_0001, 32'd1,  5'd5, 32'h8000_0000, 1'b1, w);
        send_main(3'b111, 32'h1234_5678, 32'd5,  5'd6, 32'h1234_5678, 1'b1, w);
        send_main(3'b010, 32'h7FFF_FFF0, 32'd4,  5'd7, 32'h07FF_FFFF, 1'b1, w);
        send_main(3'b100, 32'h1234_5678, 32'd8,  5'd8, 32'h7812_3456, 1'b1, w);
        send_main(3'b000, 32'hDEAD_BEEF, 32'd32, 5'd9, 32'hDEAD_BEEF, 1'b1, w);
        drain("directed_drain");

        for (int i = 0; i < 8; i++) begin
            send_main(3'b000, 32'h1, 32'(i), 5'(i), 32'h1 << i, 1'b1, w);
            chk("stream_ready_waits", 64'(w), 64'd0);
        end
        drain("stream_drain");

        m_irdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_main(3'b001, 32'hF000_0000, 32'(i * 4), 5'(8 + i), 32'hF000_0000 >> (i * 4), 1'b0, w);
            chk("bp_fill_waits", 64'(w), 64'd0);
        end
        m_valid = 1'b1; m_op = 3'b001; m_a = 32'hF000_0000; m_b = 32'd12; m_tag = 5'd11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready_low", 64'(m_ordy), 64'd0);
            chk("bp_valid_held", 64'(m_ovalid), 64'd1);
            chk("bp_result_stable", 64'(m_res), 64'hF000_0000);
            chk("bp_tag_stable", 64'(m_otag), 64'd8);
            @(posedge clk); #1;
        end
        m_irdy = 1'b1;
        send_main(3'b001, 32'hF000_0000, 32'd12, 5'd11, 32'h000F_0000, 1'b0, w);
        drain("bp_drain");

        send_main(3'b011, 32'h1, 32'd1, 5'd12, 32'h2, 1'b1, w);
        send_main(3'b011, 32'h1, 32'd2, 5'd13, 32'h4, 1'b1, w);
        send_main(3'b011, 32'h1, 32'd3, 5'd14, 32'h8, 1'b1, w);
        m_valid = 1'b1; m_op = 3'b000; m_a = 32'hFF; m_b = 32'd0; m_tag = 5'd15; m_flush = 1'b1;
        @(posedge clk); #1;
        m_flush = 1'b0; m_valid = 1'b0;
        mq.delete();
        @(negedge clk);
        chk("flush_valid", 64'(m_ovalid), 64'd0);
        chk("flush_busy", 64'(m_busy), 64'd0);
        @(posedge clk); #1;
        send_main(3'b100, 32'hF, 32'd4, 5'd16, 32'hF000_0000, 1'b1, w);
        drain("flush_drain");

        send_main(3'b010, 32'hF000_0000, 32'd8, 5'd17, 32'hFFF0_0000, 1'b1, w);
        send_main(3'b010, 32'hF000_0000, 32'd8, 5'd18, 32'hFFF0_0000, 1'b1, w);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_valid", 64'(m_ovalid), 64'd0);
        chk("midreset_busy", 64'(m_busy), 64'd0);
        chk("midreset_result", 64'(m_res), 64'd0);
        chk("midreset_tag", 64'(m_otag), 64'd0);
        mq.delete();
        @(negedge clk); rst_n = 1'b1; #1;
        chk("midreset_ready", 64'(m_ordy), 64'd1);
        @(posedge clk); #1;
        send_main(3'b010, 32'h8000_0000, 32'd1, 5'd19, 32'hC000_0000, 1'b1, w);
        drain("midreset_drain");

        for (int op = 0; op < 6; op++) begin
            for (int sh = 0; sh < 64; sh++) begin
                send_sweep(3'(op), {$urandom, $urandom}, 32'(sh), 5'(sh));
            end
        end
        drain("sweep_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined shift/rotate unit for the RV32/RV64 execute stage. It replaces the single-cycle combinational arithmetic shifter.
- Supports logical left, logical right, arithmetic right, rotate left and rotate right.
- Log-shifter levels are applied largest-first and split across registered stages. Stages are joined by a valid/ready handshake with backpressure, flush and a pass-through tag for writeback matching.

Parameters:
- XLEN, 32, data width; power of two, 8..64.
- LVLS_PER_STAGE, 2, shifter levels per pipeline stage; 1..log2(XLEN).
- TAG_W, 5, width of the side-band tag carried with each operation (e.g. rd index).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous kill of all in-flight operations.
- i_valid  in  1  input operation valid.
- o_ready  out  1  unit can accept an input this cycle.
- i_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 pass-through.
- i_a  in  XLEN  operand to shift.
- i_b  in  XLEN  shift amount; only b[log2(XLEN)-1:0] used.
- i_tag  in  TAG_W  side-band tag.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  XLEN  shifted value.
- o_tag  out  TAG_W  tag of o_result.
- o_busy  out  1  any stage holds a valid operation.

Behaviour:

Stage structure and latency:
- L = log2(XLEN); STAGES = ceil(L / LVLS_PER_STAGE).
- Level k shifts by 2^(L-1-k) when the matching shamt bit is set.
- Stage s applies levels s*LVLS_PER_STAGE .. min(L, (s+1)*LVLS_PER_STAGE)-1, then registers its result. The last stage register drives the outputs.
- Each stage register holds: valid, data, op, remaining shamt bits, tag.
- Latency is exactly STAGES cycles from the accept edge to o_valid, provided there is no backpressure.

Arithmetic:
- SRA fill bit is the operand's original bit XLEN-1, captured at accept and carried down the pipe.
- SRL and SLL fill with 0.
- Rotates wrap the bits shifted out back in.
- shamt = 0 or a pass-through op returns i_a unchanged.

Handshake:
- An input is accepted when i_valid && o_ready.
- Stage s advances when it is valid and (stage s+1 is empty or stage s+1 advances). The last stage advances on i_ready.
- o_ready = !valid[0] || stage 0 advances. This is combinational from i_ready.
- While o_valid && !i_ready, o_result and o_tag hold stable, and no stage overwrites a valid stage.
- Results emerge in acceptance order; there is no drop and no duplication.
- Full condition: all STAGES valid and i_ready low, which forces o_ready low.

Flush:
- i_flush clears every stage valid at the next edge.
- A same-cycle input is not accepted, even though o_ready may be high.
- A same-cycle output handshake still completes for the consumer.
- Data and tag registers may keep stale values.

Reset:
- Asynchronous assert clears all valids.
- Outputs after reset: o_valid=0, o_busy=0, o_result=0, o_tag=0, o_ready=1 once reset deasserts.
- Reset mid-operation discards all in-flight work.
- Data registers reset to 0.

o_busy:
- OR of all stage valids, registered with the stages.

Test Plan:
- XLEN=32, LVLS_PER_STAGE=2 (STAGES=3), i_ready=1: SRA a=0x8000_0000, b=31 -> o_result=0xFFFF_FFFF with o_valid exactly 3 cycles after accept; SRL with the same operands -> 0x0000_0001.
- Shamt masking and left ops: SLL a=0x1, b=0x25 -> 0x0000_0020; ROL a=0x8000_0001, b=4 -> 0x0000_0018; ROR a=0x1, b=1 -> 0x8000_0000; op=111, a=0x1234_5678 -> 0x1234_5678.
- Back-to-back stream: 8 ops, tags 0..7, i_ready=1 -> one result per cycle after 3-cycle fill, tags in order 0..7, o_ready constantly 1.
- Backpressure: i_ready=0 while feeding 4 ops -> o_ready=0 after 3 accepts, 4th held; o_result stable; release i_ready -> all 4 delivered in order, no loss.
- Flush: 3 ops in flight plus i_valid=1 and i_flush=1 in the same cycle -> next cycle o_valid=0, o_busy=0, the flush-cycle op is never produced; a new op issued afterwards completes with 3-cycle latency.
- Reset mid-flight: assert i_rst_n=0 asynchronously with 2 ops in flight -> o_valid=0, o_busy=0, o_result=0 immediately; after release the first new op produces a correct result.
- Sweep: XLEN=64 with LVLS_PER_STAGE in {1,3,6} -> STAGES in {6,2,1}; all 5 ops checked against a reference model across random a and all shamt 0..63.
